// File: rtl/seg7_scan_driver_if.sv
// Signal bundle between the upstream timer stage / display pins and the
// two-digit seven-segment scan driver.
interface seg7_scan_driver_if;
    logic [3:0] muxed_digits;
    logic       en_low_digit;
    logic       en_high_digit;
    logic [3:0] brightness;
    logic       lz_blank;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame_tick;
    logic       proto_err;

    modport master (
        output muxed_digits, en_low_digit, en_high_digit, brightness, lz_blank,
        input  seg, an, frame_tick, proto_err
    );

    modport slave (
        input  muxed_digits, en_low_digit, en_high_digit, brightness, lz_blank,
        output seg, an, frame_tick, proto_err
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Two-digit multiplexed seven-segment driver: captures BCD digits from a
// time-multiplexed bus and scans them with blanking and PWM brightness.
//
// state   | meaning
// BLANK_L | all anodes off before the low digit; frame values load on exit
// SHOW_L  | low digit shown for counter < bright_reg
// BLANK_H | all anodes off before the high digit
// SHOW_H  | high digit shown, optionally suppressed when it is zero
module seg7_scan_driver #(
    parameter int DWELL_CYCLES = 16,
    parameter int BLANK_CYCLES = 2
) (
    input logic clk,
    input logic reset,
    seg7_scan_driver_if.slave bus
);
    typedef enum logic [1:0] {BLANK_L, SHOW_L, BLANK_H, SHOW_H} state_t;

    state_t     state, state_nxt;
    logic [8:0] cnt;
    logic       last;
    logic [3:0] shadow_low, shadow_high;
    logic [3:0] disp_low, disp_high;
    logic [3:0] bright_reg;
    logic       proto_err;
    logic       active_l, active_h;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        last      = 1'b0;
        unique case (state)
            BLANK_L: begin
                last = (cnt == 9'(BLANK_CYCLES - 1));
                if (last) state_nxt = SHOW_L;
            end
            SHOW_L: begin
                last = (cnt == 9'(DWELL_CYCLES - 1));
                if (last) state_nxt = BLANK_H;
            end
            BLANK_H: begin
                last = (cnt == 9'(BLANK_CYCLES - 1));
                if (last) state_nxt = SHOW_H;
            end
            SHOW_H: begin
                last = (cnt == 9'(DWELL_CYCLES - 1));
                if (last) state_nxt = BLANK_L;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= BLANK_L;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= last ? '0 : cnt + 9'd1;
        end
    end

    // Frame values are taken from the pre-edge shadows, so a same-edge write lands next frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_low  <= '0;
            shadow_high <= '0;
            disp_low    <= '0;
            disp_high   <= '0;
            bright_reg  <= '0;
            proto_err   <= 1'b0;
        end else begin
            if (bus.en_low_digit && bus.en_high_digit) proto_err <= 1'b1;
            else if (bus.en_low_digit)                 shadow_low  <= bus.muxed_digits;
            else if (bus.en_high_digit)                shadow_high <= bus.muxed_digits;
            if (state == BLANK_L && last) begin
                disp_low   <= shadow_low;
                disp_high  <= shadow_high;
                bright_reg <= bus.brightness;
            end
        end
    end

    assign active_l = (state == SHOW_L) && (cnt < {5'b0, bright_reg});
    assign active_h = (state == SHOW_H) && (cnt < {5'b0, bright_reg}) &&
                      !(bus.lz_blank && disp_high == 4'd0);

    assign bus.an         = {~active_h, ~active_l};
    assign bus.seg        = active_l ? decode(disp_low) :
                            active_h ? decode(disp_high) : 7'b1111111;
    assign bus.frame_tick = (state == SHOW_L) && (cnt == 9'd0);
    assign bus.proto_err  = proto_err;
endmodule
